seq_right_shifter: RTL and testbench
====================================

Name: seq_right_shifter

Overview:
- Iterative, multi-cycle right-shift/rotate unit for the ALU section. It is the right-direction counterpart of the combinational left barrel shifter.
- Shifts one bit position per clock under a START/BUSY/DONE handshake.
- Supports logical right, arithmetic right and rotate right.
- Used for the sra/ror-class instructions, where the CPU stalls on BUSY.

Parameters:
WIDTH, 8, operand/result width in bits (amount field = low log2(WIDTH) bits of DATA2)
CNT_W, 4, width of internal shift counter; must hold values 0..WIDTH

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  asynchronous, active-low reset
START  input  1  request pulse; sampled only in IDLE
DATA1  input  WIDTH  operand to shift
DATA2  input  WIDTH  shift amount; [2:0]=amount, [6:3]=overflow bits, [7] ignored (direction already decoded)
MODE  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 treated as 00
OUTPUT  output  WIDTH  result register; holds last result until next accepted START
BUSY  output  1  high in SHIFT and DONE states
DONE  output  1  single-cycle pulse when OUTPUT is valid

Behaviour:
- Interface: one clock CLK; reset RESET is asynchronous and active-low. While RESET=0: state=IDLE, OUTPUT=0, BUSY=0, DONE=0, counter=0. Release takes effect at the next CLK edge.
- FSM states: IDLE, SHIFT, FIN.
- IDLE, START=1 at edge:
  - Capture DATA1 into the working register and latch MODE.
  - Load counter with the effective amount N.
  - Go to FIN if N=0, else go to SHIFT.
- IDLE, START=0: hold.
- Effective amount:
  - Rotate: N = DATA2[2:0].
  - Logical/arithmetic: N = 8 if any of DATA2[6:3] is 1, else N = DATA2[2:0].
  - Saturation yields all zeros (logical) or all sign bits (arithmetic).
- SHIFT, each edge:
  - Working register shifts right by 1.
  - Fill bit is 0 (logical), current MSB (arithmetic), or current LSB (rotate).
  - Counter decrements by 1. When the counter goes from 1 to 0, go to FIN.
- FIN:
  - DONE=1 for exactly this cycle; BUSY=1.
  - OUTPUT equals the final working register, and is updated on entry to FIN.
  - Next edge returns to IDLE unconditionally.
- Latency: DONE is high in the cycle following edge N+1, counting the START-capture edge as edge 1. Examples: N=0 gives 1 cycle; N=8 gives 9 cycles.
- OUTPUT changes only on entry to FIN. It is stable during IDLE and SHIFT. No combinational path from DATA1/DATA2 to OUTPUT.
- START while BUSY=1 is ignored, with no queuing. DATA1, DATA2 and MODE changes after capture do not affect the operation in flight.
- START asserted in FIN is ignored. It is accepted only on the following IDLE cycle.
- RESET asserted mid-operation aborts immediately: OUTPUT=0, DONE is never pulsed for the aborted operation.
- MODE=11 behaves exactly as MODE=00.

Test Plan:
- Logical right: DATA1=0xB4, DATA2=0x03, MODE=00, START 1 cycle. Required: BUSY high next cycle; DONE pulse 4 edges after capture; OUTPUT=0x16.
- Arithmetic right: DATA1=0xB4, DATA2=0x02, MODE=01. Required: OUTPUT=0xED, DONE after 3 edges. Saturation case: DATA1=0x80, DATA2=0x09, MODE=01 gives OUTPUT=0xFF after 9 edges.
- Rotate right: DATA1=0xB4, DATA2=0x0B, MODE=10. Only [2:0]=3 is used. Required: OUTPUT=0x96 after 4 edges.
- Zero/saturate: DATA1=0xB4, DATA2=0x00, MODE=00 gives OUTPUT=0xB4 with DONE 1 cycle after capture. DATA2=0x48, MODE=00 gives OUTPUT=0x00 after 9 edges.
- Handshake: START held high continuously, with DATA1 changed mid-operation. Required: back-to-back operations separated by at least one IDLE cycle; each result is computed from the DATA1 captured at its own START; exactly one DONE pulse per operation.
- Reset mid-op: DATA1=0xFF, DATA2=0x05, MODE=00; assert RESET=0 asynchronously during SHIFT. Required: OUTPUT=0, BUSY=0, DONE=0 immediately, with no DONE pulse after release. A subsequent op then completes normally.

Source files
------------

// File: rtl/seq_right_shifter.sv
// Iterative right shifter: logical, arithmetic or rotate right, one bit per clock,
// with a START/BUSY/DONE handshake. OUTPUT is a register loaded only on entry to FIN.
module seq_right_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] OUTPUT,
  output logic             BUSY,
  output logic             DONE
);

  // state | meaning
  // IDLE  | waiting for START; OUTPUT holds the previous result
  // SHIFT | one right shift per clock until the counter reaches zero
  // FIN   | DONE pulse, OUTPUT valid; always returns to IDLE

  localparam int AMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   cnt;

  logic               ovf;
  logic [CNT_W-1:0]   amt_eff;
  logic               fill;
  logic [WIDTH-1:0]   work_nxt;
  logic               unused_dir;

  // Top bit of DATA2 carries the already-decoded direction and is not needed here.
  assign unused_dir = DATA2[WIDTH-1];

  // Rotation wraps, so only the low amount bits matter; other modes saturate.
  always_comb begin
    ovf     = |DATA2[WIDTH-2:AMT_W];
    amt_eff = CNT_W'(DATA2[AMT_W-1:0]);
    if ((MODE != 2'b10) && ovf)
      amt_eff = CNT_W'(WIDTH);
  end

  always_comb begin
    fill = 1'b0;
    case (mode_q)
      2'b01:   fill = work[WIDTH-1];
      2'b10:   fill = work[0];
      default: fill = 1'b0;
    endcase
    work_nxt = {fill, work[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      work   <= '0;
      mode_q <= 2'b00;
      cnt    <= '0;
      OUTPUT <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            work   <= DATA1;
            mode_q <= MODE;
            cnt    <= amt_eff;
            BUSY   <= 1'b1;
            if (amt_eff == '0) begin
              OUTPUT <= DATA1;
              DONE   <= 1'b1;
              state  <= FIN;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            OUTPUT <= work_nxt;
            DONE   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Scoreboard bench for seq_right_shifter: stimulus pushes expected result and DONE cycle,
// a monitor pops on every DONE pulse and checks value, timing and OUTPUT stability.
module tb_seq_right_shifter;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [1:0] MODE;
  logic [7:0] OUTPUT;
  logic       BUSY;
  logic       DONE;

  typedef struct {
    logic [7:0] val;
    int         done_cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_out = 8'h00;

  seq_right_shifter #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
    .MODE(MODE), .OUTPUT(OUTPUT), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: DONE pops the scoreboard; while busy, OUTPUT must keep the last result.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (!RESET) begin
      model_out = 8'h00;
    end else if (DONE) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(DONE), 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", 32'(OUTPUT), 32'(e.val));
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("busy_with_done", 32'(BUSY), 32'd1);
        model_out = e.val;
      end
    end else if (BUSY) begin
      chk("out_stable", 32'(OUTPUT), 32'(model_out));
    end
  end

  task automatic run_op(input logic [7:0] d1, input logic [7:0] d2, input logic [1:0] m,
                        input logic [7:0] exp, input int n);
    @(negedge CLK);
    DATA1 = d1; DATA2 = d2; MODE = m; START = 1'b1;
    q.push_back('{val: exp, done_cyc: cyc + 1 + n});
    @(posedge CLK); #1;
    START = 1'b0;
    DATA1 = ~d1;
    chk("busy_after_start", 32'(BUSY), 32'd1);
    repeat (n + 3) @(negedge CLK);
  endtask

  initial begin
    int c;
    RESET = 1'b0; START = 1'b0; DATA1 = 8'h00; DATA2 = 8'h00; MODE = 2'b00;
    repeat (2) @(negedge CLK);
    chk("rst_output", 32'(OUTPUT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    run_op(8'hB4, 8'h03, 2'b00, 8'h16, 3);  // logical
    run_op(8'hB4, 8'h02, 2'b01, 8'hED, 2);  // arithmetic
    run_op(8'h80, 8'h09, 2'b01, 8'hFF, 8);  // arithmetic saturate
    run_op(8'hB4, 8'h0B, 2'b10, 8'h96, 3);  // rotate ignores overflow bits
    run_op(8'hB4, 8'h00, 2'b00, 8'hB4, 0);  // zero amount
    run_op(8'h12, 8'h48, 2'b00, 8'h00, 8);  // logical saturate
    run_op(8'hB4, 8'h03, 2'b11, 8'h16, 3);  // mode 11 = logical
    run_op(8'h0F, 8'h07, 2'b10, 8'h1E, 7);  // rotate by 7
    run_op(8'h74, 8'h10, 2'b01, 8'h00, 8);  // positive arithmetic saturate
    run_op(8'hB4, 8'h07, 2'b00, 8'h01, 7);  // logical max amount
    run_op(8'hB4, 8'h80, 2'b00, 8'hB4, 0);  // bit 7 ignored
    run_op(8'h5A, 8'h78, 2'b10, 8'h5A, 0);  // rotate with only overflow bits set

    // START held high, DATA1 changed during the first operation.
    @(negedge CLK);
    DATA1 = 8'h3C; DATA2 = 8'h01; MODE = 2'b00; START = 1'b1;
    c = cyc + 1;
    q.push_back('{val: 8'h1E, done_cyc: c + 1});
    q.push_back('{val: 8'h61, done_cyc: c + 4});
    @(posedge CLK); #1;
    DATA1 = 8'hC3;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("idle_gap_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    START = 1'b0; DATA1 = 8'hFF;
    repeat (5) @(negedge CLK);

    // Reset in the middle of a shift: no result and no DONE may follow.
    @(negedge CLK);
    DATA1 = 8'hFF; DATA2 = 8'h05; MODE = 2'b00; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #2;
    RESET = 1'b0;
    #1;
    chk("abort_output", 32'(OUTPUT), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (10) @(negedge CLK);
    chk("abort_no_busy", 32'(BUSY), 32'd0);

    run_op(8'hC8, 8'h02, 2'b00, 8'h32, 2);  // normal op after abort

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
